mux4_rr_arbiter: RTL and testbench
==================================

// Module: mux4_rr_arbiter
// PURPOSE
//  Round-robin arbiter/sequencer sharing one 4:1 data mux among four requesters.
//  Chooses the winner, drives the mux select and forwards the winner's data on a valid/ready output port.
//  A grant lasts up to MAX_BURST beats, then rotates.
//  Sits between four stream sources and one downstream consumer.
// PARAMETERS
//  WIDTH      8   data width per requester
//  MAX_BURST  4   max accepted beats per grant (>=1); beat counter is $clog2(MAX_BURST+1) bits
// PORTS
//  clk        in   1        clock, rising edge
//  rst        in   1        synchronous reset, active-high
//  req        in   4        per-requester valid; data must be held stable while req=1 and not accepted
//  din        in   4*WIDTH  requester data, requester i at din[i*WIDTH +: WIDTH]
//  in_ready   out  4        per-requester accept strobe = gnt[i] & dout_ready & req[i]
//  gnt        out  4        one-hot grant, registered; 0 when idle
//  sel        out  2        registered mux select = index of gnt; holds last value when idle
//  dout       out  WIDTH    din slice selected by sel; 0 when no grant
//  dout_valid out  1        = granted & req[sel]
//  dout_ready in   1        downstream ready
//  busy       out  1        1 while in GRANT state
// BEHAVIOUR
//  Reset: gnt=0, sel=0, busy=0, dout_valid=0, dout=0, beat count=0, state=IDLE.
//  Reset: last-served pointer=3, so requester 0 has top priority first.
//  FSM, two states:
//   IDLE: if |req, load gnt/sel with the RR winner next cycle and go to GRANT.
//   IDLE latency: req rising at cycle N -> gnt valid at N+1.
//   GRANT: transfer when dout_valid & dout_ready; each transfer increments the beat count.
//  Release of a grant occurs when either:
//   - a transfer happens with beat count == MAX_BURST-1, or
//   - req[sel]=0 while granted; this drop release takes no beat.
//  On release:
//   - pointer := sel; beat count := 0.
//   - Same-cycle re-arbitration on current req; the released requester is lowest priority.
//   - Winner found -> stay in GRANT with the new gnt/sel next cycle, no bubble.
//   - No winner -> IDLE, gnt=0.
//  RR order: search sel+1, sel+2, sel+3, sel (mod 4); first req=1 wins.
//   - Index arithmetic is 2-bit wrap.
//  Backpressure: dout_ready=0 -> no transfer; count, gnt and sel are frozen.
//   - dout stays stable because the requester holds din.
//  gnt never changes except at a release or at reset.
//   - Grant is never granted to a requester whose req=0.
//  Reset asserted mid-burst: next edge forces the reset values above.
//   - No partial beat is accepted in the reset cycle: in_ready=0 while rst=1.
//  MAX_BURST=1: rotate after every beat.
// CONFIGURATION
//  Macro MUX4_ARB_LOCK_EN.
//  Defined:
//   - Adds input port lock[3:0] after din.
//   - While lock[sel]=1 the MAX_BURST limit is ignored; the counter saturates at MAX_BURST-1.
//   - Release occurs on req[sel]=0, or on a transfer with lock[sel]=0 and count==MAX_BURST-1.
//  Undefined: no lock port; strict MAX_BURST rotation as above.
// TESTING
//  1. rst=1 for 2 cycles with req=4'b1111:
//     -> gnt=0, dout_valid=0, in_ready=0.
//     Release rst:
//     -> gnt=4'b0001 on the next cycle.
//  2. req=4'b1111, dout_ready=1, MAX_BURST=4, din[i]=8'hA0+i:
//     -> grants 0,1,2,3,0, 4 beats each, no bubbles.
//     -> dout=A0..A3 in order.
//  3. Granted to 1, dout_ready=0 for 5 cycles mid-burst:
//     -> dout=A1 steady, gnt=4'b0010 steady, beat count unchanged.
//     -> Burst completes after ready returns.
//  4. Granted to 2, req[2] drops after 1 beat, req=4'b1001:
//     -> next cycle gnt=4'b1000, then 4'b0001.
//  5. rst pulsed 1 cycle mid-burst on requester 3:
//     -> gnt=0, busy=0 next cycle.
//     -> Re-arbitration restarts from requester 0.
//  6. MUX4_ARB_LOCK_EN, lock[1]=1 for 10 beats, all req=1:
//     -> gnt=4'b0010 held 10 beats.
//     -> Rotates to 2 on the first beat with lock[1]=0.

Source files
------------

// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: round-robin arbiter steering one 4:1 data mux onto a
// valid/ready output. A grant lasts up to MAX_BURST accepted beats, or ends
// early when the granted requester drops req, then rotates without a bubble.
// Optional feature macro: MUX4_ARB_LOCK_EN (adds lock[3:0]; a locked grant
// ignores the MAX_BURST limit).

// Per-requester slice: accept strobe and the data contribution to the AND-OR mux.
module mux4_rr_lane #(
  parameter int W = 8
) (
  input  logic         gnt,
  input  logic         req,
  input  logic         rdy_ok,
  input  logic [W-1:0] din,
  output logic         in_ready,
  output logic [W-1:0] dout_part
);
  assign in_ready  = gnt & req & rdy_ok;
  assign dout_part = gnt ? din : '0;
endmodule

module mux4_rr_arbiter #(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         req,
  input  logic [4*WIDTH-1:0] din,
`ifdef MUX4_ARB_LOCK_EN
  input  logic [3:0]         lock,
`endif
  output logic [3:0]         in_ready,
  output logic [3:0]         gnt,
  output logic [1:0]         sel,
  output logic [WIDTH-1:0]   dout,
  output logic               dout_valid,
  input  logic               dout_ready,
  output logic               busy
);
  localparam int NUM_LANES = 4;
  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] LAST = CW'(MAX_BURST - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                            state_q, state_d;
  logic [3:0]                        gnt_d;
  logic [1:0]                        sel_d, ptr_q, ptr_d;
  logic [CW-1:0]                     cnt_q, cnt_d;
  logic                              granted, xfer, at_last, lock_cur, release_g;
  logic [1:0]                        base, idx, win_idx;
  logic                              win_found;
  logic [NUM_LANES-1:0][WIDTH-1:0]   dout_part;

  assign granted = (state_q == GRANT);
  assign busy    = granted;

  // Nothing is offered or accepted while reset is asserted.
  assign dout_valid = granted & req[sel] & ~rst;
  assign xfer       = dout_valid & dout_ready;
  assign at_last    = (cnt_q == LAST);

`ifdef MUX4_ARB_LOCK_EN
  assign lock_cur = lock[sel];
`else
  assign lock_cur = 1'b0;
`endif

  // A drop of req[sel] releases without a beat; otherwise the last beat of a burst.
  assign release_g = granted & (~req[sel] | (xfer & at_last & ~lock_cur));

  generate
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      mux4_rr_lane #(.W(WIDTH)) u_lane (
        .gnt       (gnt[i]),
        .req       (req[i]),
        .rdy_ok    (dout_ready & ~rst),
        .din       (din[i*WIDTH +: WIDTH]),
        .in_ready  (in_ready[i]),
        .dout_part (dout_part[i])
      );
    end
  endgenerate

  // One-hot gnt makes the OR of masked slices equal to din[sel], or 0 when idle.
  always_comb begin
    dout = '0;
    for (int i = 0; i < NUM_LANES; i++) dout = dout | dout_part[i];
  end

  // Round-robin search from base+1 wrapping back to base itself (lowest priority).
  always_comb begin
    base      = granted ? sel : ptr_q;
    idx       = base;
    win_found = 1'b0;
    win_idx   = base;
    for (int k = 1; k <= NUM_LANES; k++) begin
      idx = base + 2'(k);
      if (!win_found && req[idx]) begin
        win_found = 1'b1;
        win_idx   = idx;
      end
    end
  end

  // Next-state: start a grant from IDLE, count beats, release and re-arbitrate.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt;
    sel_d   = sel;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          gnt_d   = 4'b0001 << win_idx;
          sel_d   = win_idx;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (release_g) begin
          ptr_d = sel;
          cnt_d = '0;
          if (win_found) begin
            gnt_d = 4'b0001 << win_idx;
            sel_d = win_idx;
          end else begin
            gnt_d   = 4'b0000;
            state_d = IDLE;
          end
        end else if (xfer && !at_last) begin
          // A locked grant sits at LAST until lock falls or req drops.
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; pointer resets to 3 so requester 0 is served first.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt     <= 4'b0000;
      sel     <= 2'd0;
      ptr_q   <= 2'd3;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt     <= gnt_d;
      sel     <= sel_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter: a per-cycle vector table for the main
// MAX_BURST=4 instance, plus hand sequences for MAX_BURST=1 and, when
// MUX4_ARB_LOCK_EN is defined, the lock feature.
module tb_mux4_rr_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] din;
  logic        dout_ready;
  logic [3:0]  lock;
  logic [3:0]  in_ready, gnt, in_ready1, gnt1;
  logic [1:0]  sel, sel1;
  logic [7:0]  dout, dout1;
  logic        dout_valid, busy, dout_valid1, busy1;

  int pass_cnt = 0;
  int total    = 0;

  always #5 clk = ~clk;

  mux4_rr_arbiter #(.WIDTH(8), .MAX_BURST(4)) u_dut (
    .clk(clk), .rst(rst), .req(req), .din(din),
`ifdef MUX4_ARB_LOCK_EN
    .lock(lock),
`endif
    .in_ready(in_ready), .gnt(gnt), .sel(sel), .dout(dout),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .busy(busy)
  );

  mux4_rr_arbiter #(.WIDTH(8), .MAX_BURST(1)) u_dut1 (
    .clk(clk), .rst(rst), .req(req), .din(din),
`ifdef MUX4_ARB_LOCK_EN
    .lock(4'b0000),
`endif
    .in_ready(in_ready1), .gnt(gnt1), .sel(sel1), .dout(dout1),
    .dout_valid(dout_valid1), .dout_ready(dout_ready), .busy(busy1)
  );

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       rdy;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       dv;
    logic [7:0] dout;
    logic [3:0] ir;
    logic       busy;
  } vec_t;

  vec_t tbl[$];

  task automatic v(input logic r, input logic [3:0] rq, input logic rd,
                   input logic [3:0] g, input logic [1:0] s, input logic d,
                   input logic [7:0] o, input logic [3:0] ir, input logic b);
    vec_t e;
    e.rst = r; e.req = rq; e.rdy = rd; e.gnt = g; e.sel = s;
    e.dv = d; e.dout = o; e.ir = ir; e.busy = b;
    tbl.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else pass_cnt++;
  endtask

  initial begin
    logic [3:0] rot [5];
    logic       found;
    rot = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    // rst req rdy | gnt sel dv dout ir busy
    v(1, 4'hF, 1, 4'h0, 0, 0, 8'h00, 4'h0, 0);
    v(1, 4'hF, 1, 4'h0, 0, 0, 8'h00, 4'h0, 0);
    v(0, 4'hF, 1, 4'h0, 0, 0, 8'h00, 4'h0, 0);
    for (int i = 0; i < 4; i++) v(0, 4'hF, 1, 4'h1, 0, 1, 8'hA0, 4'h1, 1);
    for (int i = 0; i < 4; i++) v(0, 4'hF, 1, 4'h2, 1, 1, 8'hA1, 4'h2, 1);
    for (int i = 0; i < 4; i++) v(0, 4'hF, 1, 4'h4, 2, 1, 8'hA2, 4'h4, 1);
    for (int i = 0; i < 4; i++) v(0, 4'hF, 1, 4'h8, 3, 1, 8'hA3, 4'h8, 1);
    for (int i = 0; i < 4; i++) v(0, 4'hF, 1, 4'h1, 0, 1, 8'hA0, 4'h1, 1);
    // requester 1: two beats, five stalled cycles, two more beats
    for (int i = 0; i < 2; i++) v(0, 4'hF, 1, 4'h2, 1, 1, 8'hA1, 4'h2, 1);
    for (int i = 0; i < 5; i++) v(0, 4'hF, 0, 4'h2, 1, 1, 8'hA1, 4'h0, 1);
    for (int i = 0; i < 2; i++) v(0, 4'hF, 1, 4'h2, 1, 1, 8'hA1, 4'h2, 1);
    // requester 2: one beat, then req[2] drops
    v(0, 4'hF, 1, 4'h4, 2, 1, 8'hA2, 4'h4, 1);
    v(0, 4'h9, 1, 4'h4, 2, 0, 8'hA2, 4'h0, 1);
    for (int i = 0; i < 4; i++) v(0, 4'h9, 1, 4'h8, 3, 1, 8'hA3, 4'h8, 1);
    for (int i = 0; i < 4; i++) v(0, 4'h9, 1, 4'h1, 0, 1, 8'hA0, 4'h1, 1);
    // reset pulse mid-burst on requester 3
    v(0, 4'h9, 1, 4'h8, 3, 1, 8'hA3, 4'h8, 1);
    v(1, 4'h9, 1, 4'h8, 3, 0, 8'hA3, 4'h0, 1);
    v(0, 4'h9, 1, 4'h0, 0, 0, 8'h00, 4'h0, 0);
    v(0, 4'h9, 1, 4'h1, 0, 1, 8'hA0, 4'h1, 1);
    // drop to requester 2, then everything idles; sel holds 2
    v(0, 4'h4, 1, 4'h1, 0, 0, 8'hA0, 4'h0, 1);
    v(0, 4'h0, 1, 4'h4, 2, 0, 8'hA2, 4'h0, 1);
    v(0, 4'h0, 1, 4'h0, 2, 0, 8'h00, 4'h0, 0);
    v(0, 4'h2, 1, 4'h0, 2, 0, 8'h00, 4'h0, 0);
    // lone requester 1 is re-granted back-to-back after its burst
    for (int i = 0; i < 5; i++) v(0, 4'h2, 1, 4'h2, 1, 1, 8'hA1, 4'h2, 1);

    din        = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    rst        = 1'b1;
    req        = 4'hF;
    dout_ready = 1'b1;
    lock       = 4'h0;
    repeat (2) @(posedge clk);

    foreach (tbl[i]) begin
      @(negedge clk);
      rst = tbl[i].rst; req = tbl[i].req; dout_ready = tbl[i].rdy;
      #1;
      chk($sformatf("vec%0d gnt/sel/dv/dout/ir/busy", i),
          {8'h0, gnt, 2'b0, sel, 3'b0, dout_valid, dout, in_ready, 3'b0, busy},
          {8'h0, tbl[i].gnt, 2'b0, tbl[i].sel, 3'b0, tbl[i].dv, tbl[i].dout,
           tbl[i].ir, 3'b0, tbl[i].busy});
    end

    // MAX_BURST=1: grant rotates after every beat
    @(negedge clk); rst = 1'b1; req = 4'hF; dout_ready = 1'b1;
    @(negedge clk); rst = 1'b0; #1;
    chk("mb1 idle gnt", {28'h0, gnt1}, 32'h0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      chk($sformatf("mb1 rot%0d gnt", k), {28'h0, gnt1}, {28'h0, rot[k]});
    end

`ifdef MUX4_ARB_LOCK_EN
    // lock[1] holds requester 1 past MAX_BURST
    @(negedge clk); rst = 1'b1; req = 4'hF; lock = 4'b0010;
    @(negedge clk); rst = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk); #1;
      if (gnt == 4'b0010) found = 1'b1;
    end
    chk("lock reach gnt1", {31'h0, found}, 32'h1);
    for (int k = 1; k < 10; k++) begin
      @(negedge clk); #1;
      chk($sformatf("lock beat%0d gnt", k), {28'h0, gnt}, 32'h2);
    end
    @(negedge clk); lock = 4'b0000; #1;
    chk("unlock beat gnt", {28'h0, gnt}, 32'h2);
    @(negedge clk); #1;
    chk("after unlock gnt", {28'h0, gnt}, 32'h4);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
